// File: rtl/music_pkg.sv
// Shared types and constants for the music datapath controllers.
// Song ROM entries are packed {note, dur}; dur occupies the low bits.
package music_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_PAUSED,
    S_END
  } seq_state_t;

  localparam int NOTE_REST = 0;
  localparam int DUR_END   = 0;

  localparam int ADDR_W_DEF = 8;
  localparam int NOTE_W_DEF = 5;
  localparam int DUR_W_DEF  = 4;

  localparam int DUR_LSB  = 0;
  localparam int NOTE_LSB = DUR_LSB + DUR_W_DEF;

endpackage

// File: rtl/seq_beat_counter.sv
// Remaining-beat down-counter for the note sequencer, plus a one-deep pending
// flag that remembers a beat which arrived while the next entry was being fetched.
module seq_beat_counter #(
  parameter int DUR_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [DUR_W-1:0] dur_i,
  input  logic             run_i,
  input  logic             beat_i,
  input  logic             pend_set_i,
  output logic             last_o
);

  logic [DUR_W-1:0] remaining_q, remaining_d;
  logic             pending_q, pending_d;
  logic             tick;

  // A held-over beat is consumed on the first cycle the counter runs again.
  assign tick   = run_i & (beat_i | pending_q);
  assign last_o = tick & (remaining_q == DUR_W'(1));

  always_comb begin
    remaining_d = remaining_q;
    pending_d   = pending_q;
    if (clr_i) begin
      remaining_d = '0;
      pending_d   = 1'b0;
    end else if (load_i) begin
      remaining_d = dur_i;
      pending_d   = pending_q | pend_set_i;
    end else if (tick) begin
      if (remaining_q != '0) remaining_d = remaining_q - DUR_W'(1);
      pending_d = 1'b0;
    end else if (pend_set_i) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining_q <= '0;
      pending_q   <= 1'b0;
    end else begin
      remaining_q <= remaining_d;
      pending_q   <= pending_d;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Walks the song ROM and times each note in beats; gates beat_generator via beat_en.
// NOTE_SEQ_LOOP_EN: end of song restarts at address 0 instead of parking in END.
//
// state  | meaning
// IDLE   | stopped, address 0, all outputs low
// FETCH  | rom_addr presented, waiting for ROM read latency
// LOAD   | rom_data valid: decode note/dur or end of song
// PLAY   | note sounding, beats counted down
// PAUSED | playback frozen, note and remaining beats held
// END    | song finished, waiting for play or stop
module note_sequencer
  import music_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NOTE_W = NOTE_W_DEF,
  parameter int DUR_W  = DUR_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    play,
  input  logic                    pause,
  input  logic                    stop,
  input  logic                    beat,
  output logic                    beat_en,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [NOTE_W+DUR_W-1:0] rom_data,
  output logic [NOTE_W-1:0]       note,
  output logic                    note_valid,
  output logic                    busy,
  output logic                    done
);

  localparam logic [ADDR_W-1:0] AddrMax = '1;
`ifdef NOTE_SEQ_LOOP_EN
  localparam bit LoopEn = 1'b1;
`else
  localparam bit LoopEn = 1'b0;
`endif

  seq_state_t        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [NOTE_W-1:0] note_q;
  logic              note_valid_q;
  logic              beat_en_q;
  logic              done_q;
  logic              pause_pend_q;

  logic [NOTE_W-1:0] rom_note;
  logic [DUR_W-1:0]  rom_dur;
  logic              is_load, is_play, is_fetching;
  logic              dur_is_end, last;
  logic              song_end, empty_song, loop_back, go_end;
  logic              pause_req;

  assign rom_note = rom_data[DUR_LSB+DUR_W +: NOTE_W];
  assign rom_dur  = rom_data[DUR_LSB +: DUR_W];

  assign is_load     = (state_q == S_LOAD);
  assign is_play     = (state_q == S_PLAY);
  assign is_fetching = (state_q == S_FETCH) || (state_q == S_LOAD);

  // Running off the last address counts as end of song; the address never wraps.
  assign dur_is_end = (rom_dur == DUR_W'(DUR_END));
  assign song_end   = (is_load & dur_is_end) | (is_play & last & (addr_q == AddrMax));
  assign empty_song = is_load & dur_is_end & (addr_q == '0);
  assign loop_back  = LoopEn & song_end & ~empty_song;
  assign go_end     = song_end & ~loop_back;
  assign pause_req  = pause | pause_pend_q;

  seq_beat_counter #(.DUR_W(DUR_W)) u_beat_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (stop | go_end),
    .load_i    (is_load & ~dur_is_end),
    .dur_i     (rom_dur),
    .run_i     (is_play),
    .beat_i    (beat),
    .pend_set_i(beat & beat_en_q & is_fetching),
    .last_o    (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      note_q       <= '0;
      note_valid_q <= 1'b0;
      beat_en_q    <= 1'b0;
      done_q       <= 1'b0;
      pause_pend_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stop) begin
        state_q      <= S_IDLE;
        addr_q       <= '0;
        note_q       <= '0;
        note_valid_q <= 1'b0;
        beat_en_q    <= 1'b0;
        pause_pend_q <= 1'b0;
      end else if (song_end) begin
        done_q       <= 1'b1;
        pause_pend_q <= 1'b0;
        if (loop_back) begin
          state_q <= S_FETCH;
          addr_q  <= '0;
        end else begin
          state_q      <= S_END;
          note_valid_q <= 1'b0;
          beat_en_q    <= 1'b0;
        end
      end else begin
        case (state_q)
          S_IDLE, S_END: begin
            if (play && !pause) begin
              state_q      <= S_FETCH;
              addr_q       <= '0;
              beat_en_q    <= 1'b0;
              pause_pend_q <= 1'b0;
            end
          end
          S_FETCH: begin
            state_q <= S_LOAD;
            if (pause) pause_pend_q <= 1'b1;
          end
          S_LOAD: begin
            state_q      <= S_PLAY;
            note_q       <= rom_note;
            note_valid_q <= (rom_note != NOTE_W'(NOTE_REST));
            beat_en_q    <= 1'b1;
            if (pause) pause_pend_q <= 1'b1;
          end
          S_PLAY: begin
            // The final beat wins over a pause; the pause is carried across the fetch.
            if (last) begin
              state_q      <= S_FETCH;
              addr_q       <= addr_q + ADDR_W'(1);
              pause_pend_q <= pause_req;
            end else if (pause_req) begin
              state_q      <= S_PAUSED;
              beat_en_q    <= 1'b0;
              note_valid_q <= 1'b0;
              pause_pend_q <= 1'b0;
            end
          end
          S_PAUSED: begin
            if (play && !pause) begin
              state_q      <= S_PLAY;
              beat_en_q    <= 1'b1;
              note_valid_q <= (note_q != NOTE_W'(NOTE_REST));
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign beat_en    = beat_en_q;
  assign rom_addr   = addr_q;
  assign note       = note_q;
  assign note_valid = note_valid_q;
  assign done       = done_q;
  assign busy       = (state_q == S_FETCH) || (state_q == S_LOAD) ||
                      (state_q == S_PLAY)  || (state_q == S_PAUSED);

endmodule
